// File: rtl/key_io_device_pkg.sv
// Shared constants for the memory-mapped pushbutton peripheral: register map,
// KCTRL bit positions and the debounce counter sizing helper.
package key_io_device_pkg;

    localparam int NUM_KEYS = 4;

    localparam logic [31:0] KDATA_ADDR_DEFAULT = 32'hFFFF_F080;
    localparam logic [31:0] KCTRL_ADDR_DEFAULT = 32'hFFFF_F084;

    localparam int KCTRL_READY   = 0;
    localparam int KCTRL_OVERRUN = 2;

    // A one-cycle debounce still needs a 1-bit counter to stay well-formed.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/key_io_device_key_debounce.sv
// One key line: two-flop synchroniser followed by a stability counter that only
// accepts a new level after DEBOUNCE_CYCLES consecutive cycles at that level.
module key_debounce
    import key_io_device_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic stable_out,
    output logic change_out
);

    localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        sync1_d  = raw_in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_out = stable_q;
    assign change_out = (stable_d != stable_q);

endmodule

// File: rtl/key_io_device.sv
// Pushbutton peripheral on the data-memory bus: debounced key state in KDATA,
// Ready/Overrun change flags in KCTRL for polling software.
module key_io_device
    import key_io_device_pkg::*;
#(
    parameter int               DBITS           = 32,
    parameter logic [DBITS-1:0] KDATA_ADDR      = DBITS'(KDATA_ADDR_DEFAULT),
    parameter logic [DBITS-1:0] KCTRL_ADDR      = DBITS'(KCTRL_ADDR_DEFAULT),
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter bit               KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic [DBITS-1:0]    addr,
    input  logic                rd_en,
    input  logic                wr_en,
    input  logic [DBITS-1:0]    data_in,
    output logic [DBITS-1:0]    data_out
);

    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] stable;
    logic [NUM_KEYS-1:0] key_change;
    logic                change;
    logic                rd_kdata;
    logic                wr_kctrl_clear;
    logic                ready_q, ready_d;
    logic                overrun_q, overrun_d;
    logic [DBITS-1:0]    kdata;
    logic [DBITS-1:0]    kctrl;
    logic                unused_data;

    assign pressed = KEY_ACTIVE_LOW ? ~key_in : key_in;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk       (clk),
            .reset     (reset),
            .raw_in    (pressed[i]),
            .stable_out(stable[i]),
            .change_out(key_change[i])
        );
    end

    assign change         = |key_change;
    assign rd_kdata       = rd_en && (addr == KDATA_ADDR);
    assign wr_kctrl_clear = wr_en && (addr == KCTRL_ADDR) && !data_in[KCTRL_OVERRUN];

    // Only the Overrun bit of a store carries meaning.
    assign unused_data = ^(data_in & ~(DBITS'(1) << KCTRL_OVERRUN));

    always_comb begin
        ready_d = ready_q;
        if (change) begin
            ready_d = 1'b1;
        end else if (rd_kdata) begin
            ready_d = 1'b0;
        end
    end

    // A change the software has not yet seen beats a same-cycle clear.
    always_comb begin
        overrun_d = overrun_q;
        if (change && ready_q && !rd_kdata) begin
            overrun_d = 1'b1;
        end else if (wr_kctrl_clear) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        kdata                = '0;
        kdata[NUM_KEYS-1:0]  = stable;
        kctrl                = '0;
        kctrl[KCTRL_READY]   = ready_q;
        kctrl[KCTRL_OVERRUN] = overrun_q;
    end

    always_comb begin
        data_out = '0;
        if (addr == KDATA_ADDR) begin
            data_out = kdata;
        end else if (addr == KCTRL_ADDR) begin
            data_out = kctrl;
        end
    end

endmodule
